hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
// Parametrised successor of the 2-stage forwarding unit: per-operand forwarding select over N
// younger pipeline stages with strict youngest-first priority and x0 suppression, plus load-use
// stall/bubble FSM (configurable bubble count), data-memory wait stall and saturating stall stats.
// Sits between ID/EX control and the EX operand muxes / pipeline-register enables of the core.
// PARAMETERS
// REG_AW      5   register address width
// NUM_SRC     2   source operands per instruction
// FWD_STAGES  2   forwarding stages; stage 0 = EX/MEM (youngest), stage N-1 oldest (MEM/WB = 1)
// LU_BUBBLES  1   bubbles per load-use hazard (>=1; >1 for multi-cycle load return)
// CNT_W       32  statistics counter width
// PORTS
// clk            in  1                    clock, all state on rising edge
// arst_n         in  1                    asynchronous active-low reset
// id_rs          in  NUM_SRC*REG_AW       source regs of instruction in ID (src s at [s*REG_AW +: REG_AW])
// id_rs_used     in  NUM_SRC              src s actually read by ID instruction
// ex_rs          in  NUM_SRC*REG_AW       source regs of instruction in EX
// ex_rd          in  REG_AW               destination of instruction in EX
// ex_reg_write   in  1                    EX instruction writes rd
// ex_mem_read    in  1                    EX instruction is a load
// stg_rd         in  FWD_STAGES*REG_AW    destination reg per forwarding stage
// stg_reg_write  in  FWD_STAGES           regwrite per forwarding stage
// mem_req        in  1                    MEM stage has valid data-memory access
// dmem_ready     in  1                    data memory completes access this cycle
// flush_ex       in  1                    taken branch/jump redirect from EX
// stats_clr      in  1                    synchronous clear of statistics
// fwd_sel        out NUM_SRC*SEL_W        per src: 0 = regfile, k = stage k-1; SEL_W=clog2(FWD_STAGES+1)
// stall_pc       out 1                    hold PC
// stall_if_id    out 1                    hold IF/ID register
// bubble_ex      out 1                    load NOP into ID/EX
// stall_all      out 1                    freeze every pipeline register
// lu_active      out 1                    FSM in LU_STALL
// stall_cycles   out CNT_W                cycles with stall_pc=1, saturating
// bubble_count   out CNT_W                cycles with bubble_ex=1, saturating
// BEHAVIOUR
// - Reset (arst_n=0, async): state=RUN, bubble counter=0, stall_cycles=bubble_count=0; while in
//   reset all stall/bubble outputs and fwd_sel forced to 0.
// - fwd_sel[s] (combinational, 0 latency): smallest k with stg_reg_write[k] && stg_rd[k]!=0 &&
//   stg_rd[k]==ex_rs[s] gives sel=k+1; no match -> 0. Stage with rd=0 never forwards.
// - mem_stall = mem_req && !dmem_ready. When 1: stall_all=stall_pc=stall_if_id=1, bubble_ex=0,
//   FSM state and bubble counter frozen (priority over everything, incl. flush_ex).
// - lu_hit = ex_mem_read && ex_reg_write && ex_rd!=0 && any s: id_rs_used[s] && id_rs[s]==ex_rd.
// - FSM states RUN, LU_STALL; remaining-bubble counter width clog2(LU_BUBBLES).
//   RUN: flush_ex -> no stall, stay RUN (ID is wrong-path, squashed elsewhere). Else lu_hit ->
//        stall_pc=stall_if_id=bubble_ex=1; LU_BUBBLES==1 stay RUN, else LU_STALL, cnt=LU_BUBBLES-2.
//   LU_STALL: stall_pc=stall_if_id=bubble_ex=1, lu_active=1. flush_ex -> RUN, outputs 0 this cycle.
//        cnt==0 -> RUN (final bubble this cycle); else cnt-1.
// - Back-to-back hazards: new lu_hit in RUN right after LU_STALL handled as fresh hazard.
// - Stats: +1 per cycle on respective condition; hold at all-ones; stats_clr wins over increment.
// - Reset mid-stall: returns to RUN immediately, outputs 0 asynchronously.
// STRUCTURE
// - hazard_pkg (shared include): FSM state encodings, SEL_W/clog2 function, fwd_sel code constants.
// - Sub-module fwd_prio_match: one source vs FWD_STAGES stages -> SEL_W select; NUM_SRC instances.
// - Top: FSM + counter, mem_stall overlay, stats counters.
// TESTING
// - stg0 rd=5 we=1, stg1 rd=5 we=1, ex_rs0=5 -> fwd_sel0=1 (youngest wins); stg0 we=0 -> 2.
// - stg0 rd=0 we=1, ex_rs0=0 -> fwd_sel0=0; no matching stage -> 0.
// - LU_BUBBLES=2: EX load rd=7, ID rs1=7 used -> bubble_ex/stall_pc high 2 cycles, stall_cycles=2.
// - Same hazard with id_rs_used=0, or flush_ex=1 same cycle -> no stall, state stays RUN.
// - In LU_STALL, mem_req=1 dmem_ready=0 for 3 cycles -> stall_all=1, bubble_ex=0, cnt frozen, resume.
// - Force stall_cycles near all-ones -> saturates; arst_n low mid-LU_STALL -> outputs 0, state RUN.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and helpers for the hazard/forwarding unit: FSM encodings, select width
// and the regfile select code.
package hazard_forward_unit_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } lu_state_e;

  // Operand select code meaning "take the register file value"
  localparam int unsigned FWD_SEL_RF = 0;

  // Select width needed to encode regfile plus one code per forwarding stage
  function automatic int unsigned sel_width(input int unsigned n_stages);
    return $clog2(n_stages + 1);
  endfunction

  // Remaining-bubble counter width, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n_bubbles);
    return (n_bubbles > 2) ? $clog2(n_bubbles) : 1;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_prio_match.sv
// One source operand compared against every forwarding stage; the youngest matching
// stage wins and x0 never forwards.
module hazard_forward_unit_fwd_prio_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [REG_AW-1:0]            i_rs,
  input  logic [FWD_STAGES*REG_AW-1:0] i_stg_rd,
  input  logic [FWD_STAGES-1:0]        i_stg_we,
  output logic [SEL_W-1:0]             o_sel_c
);

  logic w_found;

  // Ascending scan with a found flag keeps stage 0 (youngest) as top priority
  always_comb begin
    o_sel_c = SEL_W'(FWD_SEL_RF);
    w_found = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (!w_found && i_stg_we[k] &&
          (i_stg_rd[k*REG_AW +: REG_AW] != '0) &&
          (i_stg_rd[k*REG_AW +: REG_AW] == i_rs)) begin
        o_sel_c = SEL_W'(k + 1);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects, load-use stall/bubble FSM, data-memory wait overlay and
// saturating stall statistics for the EX stage of the core.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                                    clk,
  input  logic                                    arst_n,
  input  logic [NUM_SRC*REG_AW-1:0]               id_rs,
  input  logic [NUM_SRC-1:0]                      id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0]               ex_rs,
  input  logic [REG_AW-1:0]                       ex_rd,
  input  logic                                    ex_reg_write,
  input  logic                                    ex_mem_read,
  input  logic [FWD_STAGES*REG_AW-1:0]            stg_rd,
  input  logic [FWD_STAGES-1:0]                   stg_reg_write,
  input  logic                                    mem_req,
  input  logic                                    dmem_ready,
  input  logic                                    flush_ex,
  input  logic                                    stats_clr,
  output logic [NUM_SRC*sel_width(FWD_STAGES)-1:0] fwd_sel,
  output logic                                    stall_pc,
  output logic                                    stall_if_id,
  output logic                                    bubble_ex,
  output logic                                    stall_all,
  output logic                                    lu_active,
  output logic [CNT_W-1:0]                        stall_cycles,
  output logic [CNT_W-1:0]                        bubble_count
);

  localparam int unsigned SEL_W  = sel_width(FWD_STAGES);
  localparam int unsigned CNT_BW = cnt_width(LU_BUBBLES);

  lu_state_e               r_state;
  lu_state_e               w_state_nxt;
  logic [CNT_BW-1:0]       r_cnt;
  logic [CNT_BW-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]        r_stall_cycles;
  logic [CNT_W-1:0]        r_bubble_count;
  logic [NUM_SRC*SEL_W-1:0] w_sel;
  logic                    w_lu_hit;
  logic                    w_mem_stall;
  logic                    w_lu_stall;
  logic                    w_stall_pc;
  logic                    w_bubble;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_forward_unit_fwd_prio_match #(
      .REG_AW    (REG_AW),
      .FWD_STAGES(FWD_STAGES),
      .SEL_W     (SEL_W)
    ) u_match (
      .i_rs    (ex_rs[s*REG_AW +: REG_AW]),
      .i_stg_rd(stg_rd),
      .i_stg_we(stg_reg_write),
      .o_sel_c (w_sel[s*SEL_W +: SEL_W])
    );
  end

  // Load in EX whose destination feeds a source actually read by ID
  always_comb begin
    w_lu_hit = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used[s] && (id_rs[s*REG_AW +: REG_AW] == ex_rd)) begin
        w_lu_hit = 1'b1;
      end
    end
    w_lu_hit = w_lu_hit && ex_mem_read && ex_reg_write && (ex_rd != '0);
  end

  assign w_mem_stall = mem_req && !dmem_ready;

  // Next state and load-use stall; a memory wait freezes the FSM outright
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lu_stall  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!flush_ex && w_lu_hit) begin
          w_lu_stall = 1'b1;
          if (LU_BUBBLES > 1) begin
            w_state_nxt = ST_LU_STALL;
            w_cnt_nxt   = CNT_BW'(LU_BUBBLES - 2);
          end
        end
      end
      ST_LU_STALL: begin
        if (flush_ex) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_lu_stall = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt - CNT_BW'(1);
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (w_mem_stall) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end
  end

  assign w_stall_pc = w_mem_stall || w_lu_stall;
  assign w_bubble   = w_lu_stall && !w_mem_stall;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating statistics; clear takes precedence over counting
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cycles <= '0;
      r_bubble_count <= '0;
    end else if (stats_clr) begin
      r_stall_cycles <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_stall_pc && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_bubble && (r_bubble_count != '1))   r_bubble_count <= r_bubble_count + CNT_W'(1);
    end
  end

  // Reset gates every control output low without waiting for a clock
  assign fwd_sel      = arst_n ? w_sel : '0;
  assign stall_pc     = arst_n && w_stall_pc;
  assign stall_if_id  = arst_n && w_stall_pc;
  assign bubble_ex    = arst_n && w_bubble;
  assign stall_all    = arst_n && w_mem_stall;
  assign lu_active    = arst_n && (r_state == ST_LU_STALL);
  assign stall_cycles = r_stall_cycles;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit with a two-bubble load-use setting and 4-bit
// statistics so saturation is reachable.
module tb_hazard_forward_unit;

  logic        clk;
  logic        arst_n;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [9:0]  ex_rs;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_reg_write;
  logic        mem_req;
  logic        dmem_ready;
  logic        flush_ex;
  logic        stats_clr;
  logic [3:0]  fwd_sel;
  logic        stall_pc;
  logic        stall_if_id;
  logic        bubble_ex;
  logic        stall_all;
  logic        lu_active;
  logic [3:0]  stall_cycles;
  logic [3:0]  bubble_count;

  typedef struct {
    string      tag;
    logic [1:0] f0;
    logic [1:0] f1;
    logic       spc;
    logic       bub;
    logic       sall;
    logic       lua;
    logic [3:0] sc;
    logic [3:0] bc;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [3:0] m_sc     = '0;
  logic [3:0] m_bc     = '0;

  hazard_forward_unit #(
    .REG_AW    (5),
    .NUM_SRC   (2),
    .FWD_STAGES(2),
    .LU_BUBBLES(2),
    .CNT_W     (4)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .ex_rs        (ex_rs),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .stg_rd       (stg_rd),
    .stg_reg_write(stg_reg_write),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .flush_ex     (flush_ex),
    .stats_clr    (stats_clr),
    .fwd_sel      (fwd_sel),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .stall_all    (stall_all),
    .lu_active    (lu_active),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Push the expectation for the current inputs, then pop and compare once settled
  task automatic step(input string tag, input logic [1:0] f0, input logic [1:0] f1,
                      input logic spc, input logic bub, input logic sall, input logic lua);
    exp_t e;
    exp_t o;
    e.tag = tag; e.f0 = f0; e.f1 = f1; e.spc = spc; e.bub = bub;
    e.sall = sall; e.lua = lua; e.sc = m_sc; e.bc = m_bc;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk(o.tag, "fwd0",   32'(fwd_sel[1:0]), 32'(o.f0));
    chk(o.tag, "fwd1",   32'(fwd_sel[3:2]), 32'(o.f1));
    chk(o.tag, "spc",    32'(stall_pc),     32'(o.spc));
    chk(o.tag, "sifid",  32'(stall_if_id),  32'(o.spc));
    chk(o.tag, "bub",    32'(bubble_ex),    32'(o.bub));
    chk(o.tag, "sall",   32'(stall_all),    32'(o.sall));
    chk(o.tag, "lua",    32'(lu_active),    32'(o.lua));
    chk(o.tag, "scnt",   32'(stall_cycles), 32'(o.sc));
    chk(o.tag, "bcnt",   32'(bubble_count), 32'(o.bc));
    if (!arst_n) begin
      m_sc = '0;
      m_bc = '0;
    end else if (stats_clr) begin
      m_sc = '0;
      m_bc = '0;
    end else begin
      if (o.spc && m_sc != 4'hF) m_sc = m_sc + 4'd1;
      if (o.bub && m_bc != 4'hF) m_bc = m_bc + 4'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; stg_rd = '0; stg_reg_write = '0;
    mem_req = 1'b0; dmem_ready = 1'b1; flush_ex = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic load_use_inputs();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
    id_rs = {5'd7, 5'd2}; id_rs_used = 2'b10;
  endtask

  initial begin
    arst_n = 1'b1;
    idle_inputs();
    // Hostile inputs while in reset: everything must still read zero
    stg_rd = {5'd5, 5'd5}; stg_reg_write = 2'b11; ex_rs = {5'd5, 5'd5};
    mem_req = 1'b1; dmem_ready = 1'b0;
    load_use_inputs();
    #1 arst_n = 1'b0;
    step("reset", 2'd0, 2'd0, 0, 0, 0, 0);
    arst_n = 1'b1;
    idle_inputs();
    step("idle", 2'd0, 2'd0, 0, 0, 0, 0);

    stg_rd = {5'd5, 5'd5}; stg_reg_write = 2'b11; ex_rs = {5'd5, 5'd5};
    step("fwd_youngest", 2'd1, 2'd1, 0, 0, 0, 0);
    stg_reg_write = 2'b10;
    step("fwd_older", 2'd2, 2'd2, 0, 0, 0, 0);
    stg_rd = {5'd5, 5'd3}; stg_reg_write = 2'b11; ex_rs = {5'd3, 5'd5};
    step("fwd_mixed", 2'd2, 2'd1, 0, 0, 0, 0);
    stg_rd = {5'd0, 5'd0}; stg_reg_write = 2'b11; ex_rs = '0;
    step("fwd_x0", 2'd0, 2'd0, 0, 0, 0, 0);
    stg_rd = {5'd10, 5'd9}; ex_rs = {5'd4, 5'd4};
    step("fwd_nomatch", 2'd0, 2'd0, 0, 0, 0, 0);
    idle_inputs();

    load_use_inputs();
    step("lu_hit", 2'd0, 2'd0, 1, 1, 0, 0);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    step("lu_stall", 2'd0, 2'd0, 1, 1, 0, 1);
    idle_inputs();
    step("lu_done", 2'd0, 2'd0, 0, 0, 0, 0);

    load_use_inputs(); id_rs_used = 2'b01;
    step("lu_unused", 2'd0, 2'd0, 0, 0, 0, 0);
    id_rs_used = 2'b10; flush_ex = 1'b1;
    step("lu_flush", 2'd0, 2'd0, 0, 0, 0, 0);
    idle_inputs();
    step("lu_flush_run", 2'd0, 2'd0, 0, 0, 0, 0);

    load_use_inputs();
    step("lu_hit2", 2'd0, 2'd0, 1, 1, 0, 0);
    idle_inputs();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("mem_in_lu", 2'd0, 2'd0, 1, 0, 1, 1);
    idle_inputs();
    step("lu_resume", 2'd0, 2'd0, 1, 1, 0, 1);
    step("lu_resume_done", 2'd0, 2'd0, 0, 0, 0, 0);

    load_use_inputs();
    step("lu_hit3", 2'd0, 2'd0, 1, 1, 0, 0);
    mem_req = 1'b1; dmem_ready = 1'b0;
    stg_rd = {5'd5, 5'd5}; stg_reg_write = 2'b11; ex_rs = {5'd5, 5'd5};
    arst_n = 1'b0;
    m_sc = '0; m_bc = '0;
    step("reset_mid_lu", 2'd0, 2'd0, 0, 0, 0, 0);
    arst_n = 1'b1;
    idle_inputs();
    step("after_reset", 2'd0, 2'd0, 0, 0, 0, 0);

    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 18; i++) step("sat", 2'd0, 2'd0, 1, 0, 1, 0);
    stats_clr = 1'b1;
    step("clr", 2'd0, 2'd0, 1, 0, 1, 0);
    idle_inputs();
    step("post_clr", 2'd0, 2'd0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
